// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores onto a word-addressed memory,
// with lane extraction, sign/zero extension, and read-modify-write for sub-word stores.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | memory read in flight, lane captured at next edge
// RMW_RD | read old word for a sub-word store
// WRITE  | full word presented to memory, commits at next edge
// RESP   | response held until rsp_ready
module load_store_unit #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_rd,
  output logic        mem_wrt,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        misaligned;
  logic        out_of_range;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   extract = {{24{sh[7] & ~uns}}, sh[7:0]};
      2'b01:   extract = {{16{sh[15] & ~uns}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    mask  = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {off, 3'b000};
    merge = (word & ~mask) | ((data << {off, 3'b000}) & mask);
  endfunction

  // Held low throughout reset so nothing is accepted until release.
  assign req_ready = (state == IDLE) && reset;

  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      uns_q          <= 1'b0;
      wdata_q        <= 32'h0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= 32'h0;
      mem_rd         <= 1'b0;
      mem_wrt        <= 1'b0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            if (misaligned || out_of_range) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              mem_address <= {2'b00, req_addr[31:2]};
              if (!req_we) begin
                mem_rd <= 1'b1;
                state  <= LOAD;
              end else if (req_size == 2'b10) begin
                mem_wrt        <= 1'b1;
                mem_write_data <= req_wdata;
                state          <= WRITE;
              end else begin
                mem_rd <= 1'b1;
                state  <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          rsp_rdata <= extract(mem_read_data, size_q, off_q, uns_q);
          mem_rd    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          mem_write_data <= merge(mem_read_data, wdata_q, size_q, off_q);
          mem_rd         <= 1'b0;
          mem_wrt        <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          mem_wrt   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_rd;
  logic        mem_wrt;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int total = 0;
  int bad   = 0;

  int          g_lat, g_rd, g_wr;
  logic        g_both, g_ready_hi;
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic        g_err;

  load_store_unit #(.DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:0]];
  always @(posedge clk) if (mem_wrt) mem[mem_address[9:0]] <= mem_write_data;

  // Reference: byte-granular view of memory, errors and latencies from the access rules.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    longint unsigned idx;
    int off, nb;
    longint v;
    logic [31:0] word;
    idx = longint'(addr) / 4;
    off = int'(addr % 4);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (off % nb != 0) || (idx >= 1024);
    rdata = 32'h0;
    lat = 1;
    if (!err) begin
      if (!we) begin
        v = 0;
        for (int i = 0; i < nb; i++)
          v = v | (longint'((ref_mem[idx] >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
          v = v - (longint'(1) << (8 * nb));
        rdata = v[31:0];
        lat = 2;
      end else begin
        word = ref_mem[idx];
        for (int i = 0; i < nb; i++)
          word[8 * (off + i) +: 8] = wdata[8 * i +: 8];
        ref_mem[idx] = word;
        lat = (nb == 4) ? 2 : 3;
      end
    end
  endtask

  // Drives one request (rsp_ready assumed high) and records what the DUT did.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    g_lat = 1; g_rd = 0; g_wr = 0; g_both = 1'b0; g_ready_hi = 1'b0;
    g_addr = 32'h0; g_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 16) begin
      if (mem_rd) begin g_rd++; g_addr = mem_address; end
      if (mem_wrt) begin g_wr++; g_addr = mem_address; g_wdata = mem_write_data; end
      if (mem_rd && mem_wrt) g_both = 1'b1;
      if (req_ready) g_ready_hi = 1'b1;
      @(posedge clk); #1;
      g_lat++; n++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL xact_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
    end
    if (req_ready) g_ready_hi = 1'b1;
    if (mem_rd || mem_wrt) g_both = 1'b1;
    g_rdata = rsp_rdata;
    g_err   = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wrt, mem_address, mem_write_data} !== 100'h0) begin
      bad++; $display("FAIL reset_outputs: got rsp_valid=%0b err=%0b rdata=%h rd=%0b wrt=%0b addr=%h wd=%h, required all 0",
                      rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wrt, mem_address, mem_write_data);
    end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b required 0", req_ready); end
    @(negedge clk); reset = 1'b1; #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_release: got %b required 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] er; logic ee; int el;
    logic [1:0]  sz [3] = '{2'd0, 2'd0, 2'd1};
    logic        un [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad [3] = '{32'h13, 32'h13, 32'h10};
    logic [31:0] ex [3] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_AABB};
    for (int i = 0; i < 3; i++) begin
      ref_op(1'b0, sz[i], un[i], ad[i], 32'h0, er, ee, el);
      xact(1'b0, sz[i], un[i], ad[i], 32'h0);
      total++;
      if (g_rdata !== ex[i] || g_rdata !== er || g_err !== 1'b0) begin
        bad++; $display("FAIL load_%0d_rdata: got %h err=%b required %h err=0", i, g_rdata, g_err, ex[i]);
      end
      total++;
      if (g_rd !== 1 || g_wr !== 0 || g_addr !== 32'd4 || g_lat !== 2) begin
        bad++; $display("FAIL load_%0d_bus: got rd=%0d wr=%0d addr=%h lat=%0d required 1 0 4 2", i, g_rd, g_wr, g_addr, g_lat);
      end
    end
  endtask

  task automatic test_sub_store();
    logic [31:0] er; logic ee; int el;
    ref_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, er, ee, el);
    xact(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
    total++;
    if (g_rd !== 1 || g_wr !== 1 || g_wdata !== 32'h1234_AABB || g_addr !== 32'd4) begin
      bad++; $display("FAIL substore_bus: got rd=%0d wr=%0d wdata=%h addr=%h required 1 1 1234aabb 4", g_rd, g_wr, g_wdata, g_addr);
    end
    total++;
    if (g_lat !== 3 || g_lat !== el || g_rdata !== 32'h0 || g_err !== 1'b0) begin
      bad++; $display("FAIL substore_rsp: got lat=%0d rdata=%h err=%b required 3 0 0", g_lat, g_rdata, g_err);
    end
    ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, ee, el);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    total++;
    if (g_rdata !== 32'h1234_AABB || g_rdata !== er) begin
      bad++; $display("FAIL substore_readback: got %h required 1234aabb", g_rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] er; logic ee; int el;
    ref_op(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, er, ee, el);
    xact(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    total++;
    if (g_err !== 1'b1 || g_rdata !== 32'h0 || g_lat !== 1 || g_rd !== 0 || g_wr !== 0) begin
      bad++; $display("FAIL err_misaligned: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d required 1 0 1 0 0", g_err, g_rdata, g_lat, g_rd, g_wr);
    end
    ref_op(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D, er, ee, el);
    xact(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D);
    total++;
    if (g_err !== ee || g_err !== 1'b1 || g_rdata !== 32'h0 || g_lat !== 1 || g_rd !== 0 || g_wr !== 0) begin
      bad++; $display("FAIL err_range: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d required 1 0 1 0 0", g_err, g_rdata, g_lat, g_rd, g_wr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er; logic ee; int el;
    ref_op(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, er, ee, el);
    xact(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
    total++;
    if (g_ready_hi !== 1'b0 || g_lat !== 2 || g_wr !== 1 || g_rd !== 0 || g_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL b2b_store: got ready_hi=%b lat=%0d wr=%0d rd=%0d wdata=%h required 0 2 1 0 deadbeef", g_ready_hi, g_lat, g_wr, g_rd, g_wdata);
    end
    ref_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, ee, el);
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    total++;
    if (g_rdata !== 32'hDEAD_BEEF || g_rdata !== er || g_ready_hi !== 1'b0) begin
      bad++; $display("FAIL b2b_load: got %h ready_hi=%b required deadbeef 0", g_rdata, g_ready_hi);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e1, e2, r0; logic ee, e0; int el, n;
    ref_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e1, ee, el);
    ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e2, ee, el);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h20;
    @(posedge clk); #1;
    req_addr = 32'h10;
    n = 0;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    r0 = rsp_rdata; e0 = rsp_err;
    total++;
    if (rsp_valid !== 1'b1 || r0 !== e1 || e0 !== 1'b0) begin
      bad++; $display("FAIL bp_first_rsp: got valid=%b rdata=%h err=%b required 1 %h 0", rsp_valid, r0, e0, e1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd !== 1'b0) begin
      bad++; $display("FAIL bp_handshake: got valid=%b ready=%b rd=%b required 0 1 0", rsp_valid, req_ready, mem_rd);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_rd !== 1'b1 || mem_address !== 32'd4 || req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_second_accept: got rd=%b addr=%h ready=%b required 1 4 0", mem_rd, mem_address, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e2) begin
      bad++; $display("FAIL bp_second_rsp: got valid=%b rdata=%h required 1 %h", rsp_valid, rsp_rdata, e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_wrt !== 1'b1) begin bad++; $display("FAIL abort_in_write: got mem_wrt=%b required 1", mem_wrt); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (mem_wrt !== 1'b0 || mem_rd !== 1'b0 || req_ready !== 1'b0 || mem_write_data !== 32'h0) begin
      bad++; $display("FAIL abort_async: got wrt=%b rd=%b ready=%b wd=%h required 0 0 0 0", mem_wrt, mem_rd, req_ready, mem_write_data);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem[12] !== ref_mem[12] || mem[12] !== 32'h0) begin
      bad++; $display("FAIL abort_mem: got word12=%h required 0", mem[12]);
    end
    @(negedge clk); reset = 1'b1; #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wrt, mem_address, mem_write_data} !== 100'h0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_release: got valid=%b err=%b rdata=%h rd=%b wrt=%b addr=%h wd=%h ready=%b required all 0, ready 1",
                      rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wrt, mem_address, mem_write_data, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] er, addr, wd; logic ee, we, un; logic [1:0] sz; int el, erd, ewr, diffs;
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom); un = 1'($urandom); sz = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 7) == 0) ? (32'h1000 + ($urandom & 32'hFFFF)) : 32'($urandom_range(0, 255));
      wd = $urandom;
      ref_op(we, sz, un, addr, wd, er, ee, el);
      erd = (!ee && (!we || sz != 2'd2)) ? 1 : 0;
      ewr = (!ee && we) ? 1 : 0;
      xact(we, sz, un, addr, wd);
      total++;
      if (g_rdata !== er || g_err !== ee || g_lat !== el || g_rd !== erd || g_wr !== ewr || g_both !== 1'b0) begin
        bad++; $display("FAIL rand_%0d we=%b sz=%0d un=%b addr=%h: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d strobe_bad=%b required %h %b %0d %0d %0d 0",
                        t, we, sz, un, addr, g_rdata, g_err, g_lat, g_rd, g_wr, g_both, er, ee, el, erd, ewr);
      end
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++;
    if (diffs != 0) begin bad++; $display("FAIL rand_mem_image: got %0d differing words required 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem[4] = 32'h8899_AABB;
    ref_mem[4] = 32'h8899_AABB;
    test_reset();
    test_loads();
    test_sub_store();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
